molecule_sprite_param: RTL
==========================

Name: molecule_sprite_param

Overview:
Parametrised molecule sprite for the osmosis display. It integrates its own per-frame motion engine: wall bounce, membrane permeability gating, relaunch and crossing count. It also includes the pixel-hit test against h_cnt/v_cnt, so one instance replaces a molecule wrapper plus its separate mover. Many instances, red or blue, sit in the top level and feed the pixel colour mux.

Parameters:
MOL_SIZE, 16, sprite bounding box edge in pixels (even, 4..64)
IS_RED, 0, 1 = red molecule, 0 = blue molecule
SHAPE, 0, 0 = filled square, 1 = filled diamond inside the bounding box
START_X, 40, reset/relaunch x of the top-left corner
START_Y, 100, reset/relaunch y of the top-left corner
VEL_X, 2, x step per frame (1..7)
VEL_Y, 1, y step per frame (1..7)
ARENA_X_MIN, 0 / ARENA_X_MAX, 640, horizontal arena limits; box must lie in [MIN, MAX)
ARENA_Y_MIN, 0 / ARENA_Y_MAX, 480, vertical arena limits
MEMBRANE_X, 320, left edge of membrane band
MEMBRANE_W, 4, membrane band width

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
frame  in  1  one-cycle pulse per video frame
h_cnt  in  10  current pixel column
v_cnt  in  10  current pixel row
magenta_membrane  in  1  membrane blocks all molecules
red_membrane  in  1  membrane passes red only
blue_membrane  in  1  membrane passes blue only
no_membrane  in  1  membrane absent
membrane_on  in  1  membrane enabled; 0 = everything passes
freeze  in  1  hold motion
btnD  in  1  relaunch button (level, already debounced)
is_red  out  1  constant IS_RED
is_molecule  out  1  current pixel lies inside the sprite (combinational)
pos_x  out  10  registered top-left x
pos_y  out  10  registered top-left y
side  out  1  0 = centre left of membrane centre, 1 = right
crossings  out  8  saturating membrane crossing count
blocked  out  1  one-cycle pulse on a membrane rebound

Behaviour:
- Reset (async, dominant over everything): pos = (START_X, START_Y), dir_x = +, dir_y = +, crossings = 0, blocked = 0, side computed from START_X, btnD edge register = 0, state = S_RUN.
- btnD rising edge is detected with a registered previous value.
- State machine states: S_RUN, S_FROZEN, S_RELAUNCH.
  - S_RUN: freeze = 1 → S_FROZEN. btnD rise → S_RELAUNCH.
  - S_FROZEN: freeze = 0 → S_RUN. btnD rise → S_RELAUNCH.
  - S_RELAUNCH (exactly 1 cycle): load START position, dir = (+,+), recompute side, crossings kept. Then go to S_FROZEN if freeze = 1, else S_RUN.
- Motion occurs only in S_RUN on a cycle with frame = 1. Registers update on that edge, so the new values are visible the next cycle.
  - A frame pulse in S_FROZEN or S_RELAUNCH is dropped, not deferred.
  - btnD rise in the same cycle as frame: relaunch wins, no motion step.
- Arithmetic is 11-bit signed. Candidate nx = pos_x ± VEL_X, ny = pos_y ± VEL_Y.
- Y wall: if ny < ARENA_Y_MIN → ny = ARENA_Y_MIN, dir_y = +. If ny + MOL_SIZE > ARENA_Y_MAX → ny = ARENA_Y_MAX − MOL_SIZE, dir_y = −.
- X wall: same rule on nx against the ARENA_X limits, toggling dir_x.
- Permeable is computed by priority:
  - membrane_on = 0 → 1.
  - else magenta_membrane → 0.
  - else red_membrane → IS_RED.
  - else blue_membrane → !IS_RED.
  - else no_membrane → 1.
  - else 1.
- Membrane rebound:
  - Applies when not permeable and box [nx, nx + MOL_SIZE) overlaps band [MEMBRANE_X, MEMBRANE_X + MEMBRANE_W).
  - side 0: nx = MEMBRANE_X − MOL_SIZE, dir_x = −.
  - side 1: nx = MEMBRANE_X + MEMBRANE_W, dir_x = +.
  - blocked = 1 for that one cycle.
  - The membrane check is applied after the wall check.
- side_next = (nx + MOL_SIZE/2 ≥ MEMBRANE_X + MEMBRANE_W/2). When side_next ≠ side, crossings increments, saturating at 255.
- is_molecule:
  - SHAPE 0: h in [pos_x, pos_x + MOL_SIZE) and v in [pos_y, pos_y + MOL_SIZE).
  - SHAPE 1: |h − cx| + |v − cy| < MOL_SIZE/2, where cx = pos_x + MOL_SIZE/2 and cy = pos_y + MOL_SIZE/2.
  - Both shapes use registered position only; no added latency to the pixel path.
- Membrane inputs changing mid-frame take effect at the next frame pulse only.

Test Plan:
- Reset, defaults → pos (40,100), crossings 0, side 0, blocked 0. Five frame pulses → pos (50,105).
- START_X = 302, magenta_membrane = 1, membrane_on = 1:
  - Frame 1 → x = 304, no pulse.
  - Frame 2 → x = 304 with blocked = 1 for one cycle, dir_x = −.
  - Frame 3 → x = 302.
- START_X = 302, IS_RED = 1, red_membrane = 1:
  - Frames take x to 304…314.
  - At x = 314, side goes 0 → 1 and crossings = 1.
  - Repeat with IS_RED = 0 → rebound exactly as in the magenta case.
- START_Y = 463:
  - Frame 1 → y = 464.
  - Frame 2 → y = 464, dir_y = −.
  - Frame 3 → y = 463.
- Freeze and relaunch:
  - freeze = 1 over 3 frames → pos unchanged.
  - btnD rise together with frame → next cycle pos = (START_X, START_Y), crossings unchanged, state returns to S_FROZEN.
  - Async reset mid-run → immediate return to reset values.
- Pixel hit at pos (40,100):
  - SHAPE 0: (40,100) → 1, (56,100) → 0.
  - SHAPE 1: (40,100) → 0, (48,108) → 1, (55,108) → 1, (56,108) → 0.

Source files
------------

// File: rtl/molecule_sprite_param.sv
// rtl/molecule_sprite_param.sv - self-moving molecule sprite with membrane gating and pixel-hit test
module molecule_sprite_param #(
  parameter int MOL_SIZE    = 16,
  parameter int IS_RED      = 0,
  parameter int SHAPE       = 0,
  parameter int START_X     = 40,
  parameter int START_Y     = 100,
  parameter int VEL_X       = 2,
  parameter int VEL_Y       = 1,
  parameter int ARENA_X_MIN = 0,
  parameter int ARENA_X_MAX = 640,
  parameter int ARENA_Y_MIN = 0,
  parameter int ARENA_Y_MAX = 480,
  parameter int MEMBRANE_X  = 320,
  parameter int MEMBRANE_W  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame,
  input  logic [9:0] h_cnt,
  input  logic [9:0] v_cnt,
  input  logic       magenta_membrane,
  input  logic       red_membrane,
  input  logic       blue_membrane,
  input  logic       no_membrane,
  input  logic       membrane_on,
  input  logic       freeze,
  input  logic       btnD,
  output logic       is_red,
  output logic       is_molecule,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       side,
  output logic [7:0] crossings,
  output logic       blocked
);

  // Motion arithmetic is 11-bit signed so a step past the left/top edge goes negative.
  localparam logic signed [10:0] SIZE_S   = 11'(MOL_SIZE);
  localparam logic signed [10:0] HALF_S   = 11'(MOL_SIZE / 2);
  localparam logic signed [10:0] VX_S     = 11'(VEL_X);
  localparam logic signed [10:0] VY_S     = 11'(VEL_Y);
  localparam logic signed [10:0] XMIN_S   = 11'(ARENA_X_MIN);
  localparam logic signed [10:0] XMAX_S   = 11'(ARENA_X_MAX);
  localparam logic signed [10:0] YMIN_S   = 11'(ARENA_Y_MIN);
  localparam logic signed [10:0] YMAX_S   = 11'(ARENA_Y_MAX);
  localparam logic signed [10:0] XPARK_S  = 11'(ARENA_X_MAX - MOL_SIZE);
  localparam logic signed [10:0] YPARK_S  = 11'(ARENA_Y_MAX - MOL_SIZE);
  localparam logic signed [10:0] MEM_L_S  = 11'(MEMBRANE_X);
  localparam logic signed [10:0] MEM_R_S  = 11'(MEMBRANE_X + MEMBRANE_W);
  localparam logic signed [10:0] LPARK_S  = 11'(MEMBRANE_X - MOL_SIZE);
  localparam logic signed [10:0] MEM_MID  = 11'(MEMBRANE_X + MEMBRANE_W / 2);
  localparam logic [9:0]         START_XU = 10'(START_X);
  localparam logic [9:0]         START_YU = 10'(START_Y);
  localparam logic               START_SIDE = (START_X + MOL_SIZE / 2) >= (MEMBRANE_X + MEMBRANE_W / 2);
  localparam logic               RED_B    = (IS_RED != 0);
  localparam logic [10:0]        SIZE_U   = 11'(MOL_SIZE);
  localparam logic signed [11:0] HALF_12  = 12'(MOL_SIZE / 2);

  typedef enum logic [1:0] {S_RUN, S_FROZEN, S_RELAUNCH} state_t;

  state_t state;
  state_t state_next;

  logic btn_prev;
  logic btn_rise;
  logic dir_x;
  logic dir_y;
  logic relaunch;
  logic step;

  logic signed [10:0] cur_x;
  logic signed [10:0] cur_y;
  logic signed [10:0] cand_x;
  logic signed [10:0] cand_y;
  logic signed [10:0] wall_x;
  logic signed [10:0] new_x;
  logic signed [10:0] new_y;
  logic               wall_dir_x;
  logic               new_dir_x;
  logic               new_dir_y;
  logic               permeable;
  logic               overlap;
  logic               rebound;
  logic               side_next;

  logic [10:0]        box_x_end;
  logic [10:0]        box_y_end;
  logic               in_box;
  logic signed [11:0] dx;
  logic signed [11:0] dy;
  logic signed [11:0] adx;
  logic signed [11:0] ady;
  logic               in_diamond;

  assign is_red   = RED_B;
  assign btn_rise = btnD & ~btn_prev;

  // The position snaps on the button edge itself so the pixel path shows the start
  // position at once; the one-cycle relaunch state re-asserts the same load.
  assign relaunch = btn_rise || (state == S_RELAUNCH);
  assign step     = (state == S_RUN) && frame && !btn_rise;

  // Previous button level for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) btn_prev <= 1'b0;
    else       btn_prev <= btnD;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_RUN;
    else       state <= state_next;
  end

  // FSM next-state: relaunch has priority over freeze handling.
  always_comb begin
    state_next = state;
    case (state)
      S_RUN: begin
        if (btn_rise)    state_next = S_RELAUNCH;
        else if (freeze) state_next = S_FROZEN;
      end
      S_FROZEN: begin
        if (btn_rise)     state_next = S_RELAUNCH;
        else if (!freeze) state_next = S_RUN;
      end
      S_RELAUNCH: begin
        state_next = freeze ? S_FROZEN : S_RUN;
      end
      default: state_next = S_RUN;
    endcase
  end

  // One motion step: walls first, then membrane rebound on the wall-corrected x.
  always_comb begin
    cur_x  = signed'({1'b0, pos_x});
    cur_y  = signed'({1'b0, pos_y});
    cand_x = dir_x ? (cur_x + VX_S) : (cur_x - VX_S);
    cand_y = dir_y ? (cur_y + VY_S) : (cur_y - VY_S);

    new_y     = cand_y;
    new_dir_y = dir_y;
    if (cand_y < YMIN_S) begin
      new_y     = YMIN_S;
      new_dir_y = 1'b1;
    end else if ((cand_y + SIZE_S) > YMAX_S) begin
      new_y     = YPARK_S;
      new_dir_y = 1'b0;
    end

    wall_x     = cand_x;
    wall_dir_x = dir_x;
    if (cand_x < XMIN_S) begin
      wall_x     = XMIN_S;
      wall_dir_x = 1'b1;
    end else if ((cand_x + SIZE_S) > XMAX_S) begin
      wall_x     = XPARK_S;
      wall_dir_x = 1'b0;
    end

    if (!membrane_on)          permeable = 1'b1;
    else if (magenta_membrane) permeable = 1'b0;
    else if (red_membrane)     permeable = RED_B;
    else if (blue_membrane)    permeable = !RED_B;
    else if (no_membrane)      permeable = 1'b1;
    else                       permeable = 1'b1;

    overlap = (wall_x < MEM_R_S) && ((wall_x + SIZE_S) > MEM_L_S);
    rebound = !permeable && overlap;

    new_x     = wall_x;
    new_dir_x = wall_dir_x;
    if (rebound) begin
      if (side) begin
        new_x     = MEM_R_S;
        new_dir_x = 1'b1;
      end else begin
        new_x     = LPARK_S;
        new_dir_x = 1'b0;
      end
    end

    side_next = (new_x + HALF_S) >= MEM_MID;
  end

  // Motion state: relaunch beats a same-cycle frame; frames outside S_RUN are dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pos_x     <= START_XU;
      pos_y     <= START_YU;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      side      <= START_SIDE;
      crossings <= 8'd0;
      blocked   <= 1'b0;
    end else begin
      blocked <= 1'b0;
      if (relaunch) begin
        pos_x <= START_XU;
        pos_y <= START_YU;
        dir_x <= 1'b1;
        dir_y <= 1'b1;
        side  <= START_SIDE;
      end else if (step) begin
        pos_x   <= new_x[9:0];
        pos_y   <= new_y[9:0];
        dir_x   <= new_dir_x;
        dir_y   <= new_dir_y;
        side    <= side_next;
        blocked <= rebound;
        if ((side_next != side) && (crossings != 8'hFF)) crossings <= crossings + 8'd1;
      end
    end
  end

  // Pixel hit test straight off the registered position (no extra latency).
  always_comb begin
    box_x_end = {1'b0, pos_x} + SIZE_U;
    box_y_end = {1'b0, pos_y} + SIZE_U;
    in_box    = ({1'b0, h_cnt} >= {1'b0, pos_x}) && ({1'b0, h_cnt} < box_x_end) &&
                ({1'b0, v_cnt} >= {1'b0, pos_y}) && ({1'b0, v_cnt} < box_y_end);

    dx  = signed'({2'b00, h_cnt}) - signed'({2'b00, pos_x}) - HALF_12;
    dy  = signed'({2'b00, v_cnt}) - signed'({2'b00, pos_y}) - HALF_12;
    adx = (dx < 12'sd0) ? -dx : dx;
    ady = (dy < 12'sd0) ? -dy : dy;
    in_diamond = (adx + ady) < HALF_12;

    if (SHAPE == 1) is_molecule = in_diamond;
    else            is_molecule = in_box;
  end

endmodule
